// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_responder_pkg                                         |
// | Purpose  : Shared types and helpers for the multi-cycle data-memory   |
// |            responder: FSM state encoding, index-width helper and the  |
// |            byte-within-word offset width.                             |
// | Ports    : none (package)                                             |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Byte address bits below the 32-bit word index.
  localparam int unsigned WORD_OFFSET_BITS = 2;

  // Ceiling log2, never smaller than 1 so it can size a vector directly.
  function automatic int unsigned log2c(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((32'd1 << bits) < value) begin
      bits = bits + 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_array                                                 |
// | Purpose  : DEPTH_WORDS x 32 storage with a synchronous write port and |
// |            an asynchronous read port. Contents are not reset.         |
// | Ports    : clk   - rising-edge clock                                  |
// |            we    - write enable (sampled at posedge)                  |
// |            waddr - write word index                                   |
// |            wdata - write data                                         |
// |            raddr - read word index                                    |
// |            rdata - read data (combinational)                          |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W = log2c(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] memory [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      memory[waddr] <= wdata;
    end
  end

  assign rdata = memory[raddr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_responder                                             |
// | Purpose  : Multi-cycle data-memory responder for the CPU MEM stage.   |
// |            Accepts a held load/store request, stalls the pipeline for |
// |            the configured latency, then pulses a completion strobe.   |
// | Ports    : clk, reset          - clock, synchronous active-high reset |
// |            req_read/req_write  - load / store request strobes         |
// |            req_addr/req_wdata  - byte address / store data            |
// |            stall               - access in flight, CPU must freeze    |
// |            read_data           - load result (valid with read_valid)  |
// |            read_valid          - one-cycle load completion pulse      |
// |            write_done          - one-cycle store commit pulse         |
// |            prot_err            - misaligned or read+write request     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 256,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        write_done,
  output logic        prot_err
);

  localparam int unsigned IDX_W   = log2c(DEPTH_WORDS);
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = log2c(MAX_LAT);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_wdata;
  logic               lat_write;
  logic               lat_misaligned;
  logic               latch_req;

  logic [IDX_W-1:0]   req_idx;
  logic               req_misaligned;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               unused_addr_bits;

  assign req_idx          = req_addr[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
  assign req_misaligned   = |req_addr[WORD_OFFSET_BITS-1:0];
  // Upper address bits are deliberately dropped so addresses wrap.
  assign unused_addr_bits = ^req_addr[31:IDX_W+WORD_OFFSET_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_idx        <= '0;
      lat_wdata      <= '0;
      lat_write      <= 1'b0;
      lat_misaligned <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch_req) begin
        lat_idx        <= req_idx;
        lat_wdata      <= req_wdata;
        lat_write      <= req_write;
        lat_misaligned <= req_misaligned;
      end
    end
  end

  // In BUSY states cnt counts the busy cycles still to go, including the
  // current one; cycle 0 (the IDLE acceptance cycle) already stalls, so a
  // latency of N spends N-1 cycles busy and a latency of 1 skips BUSY.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    stall      = 1'b0;
    read_valid = 1'b0;
    write_done = 1'b0;
    prot_err   = 1'b0;
    read_data  = '0;
    latch_req  = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = lat_idx;
    mem_wdata  = lat_wdata;

    case (state)
      IDLE: begin
        if (req_read || req_write) begin
          stall     = 1'b1;
          latch_req = 1'b1;
          prot_err  = req_misaligned || (req_read && req_write);
          if (req_misaligned) begin
            state_n = DONE;
            cnt_n   = '0;
          end else if (req_write) begin
            if (WRITE_LATENCY == 1) begin
              // Single-cycle store commits straight from the live inputs.
              state_n   = DONE;
              mem_we    = 1'b1;
              mem_widx  = req_idx;
              mem_wdata = req_wdata;
            end else begin
              state_n = BUSY_WR;
              cnt_n   = CNT_W'(WRITE_LATENCY - 1);
            end
          end else begin
            if (READ_LATENCY == 1) begin
              state_n = DONE;
            end else begin
              state_n = BUSY_RD;
              cnt_n   = CNT_W'(READ_LATENCY - 1);
            end
          end
        end
      end

      BUSY_RD: begin
        stall = 1'b1;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
        end
      end

      BUSY_WR: begin
        stall = 1'b1;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
          mem_we  = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
        if (lat_write) begin
          write_done = 1'b1;
        end else begin
          read_valid = 1'b1;
          read_data  = lat_misaligned ? 32'd0 : mem_rdata;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Reset drops any store that has not yet committed.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we && !reset),
    .waddr(mem_widx),
    .wdata(mem_wdata),
    .raddr(lat_idx),
    .rdata(mem_rdata)
  );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                          |
// | Purpose  : Self-checking bench for dmem_responder. A transaction-     |
// |            level model expands each request into its expected cycle   |
// |            timeline; one compare process checks every cycle.          |
// | Ports    : none                                                       |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int unsigned RL_A = 2;
  localparam int unsigned WL_A = 1;

  typedef struct {
    logic        stall;
    logic        rv;
    logic        wd;
    logic        pe;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: READ_LATENCY=2, WRITE_LATENCY=1
  logic        reset, req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        stall, read_valid, write_done, prot_err;
  logic [31:0] read_data;

  // Instance B: READ_LATENCY=2, WRITE_LATENCY=3 (reset-abort scenario)
  logic        b_reset, b_req_read, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_stall, b_read_valid, b_write_done, b_prot_err;
  logic [31:0] b_read_data;

  dmem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(RL_A), .WRITE_LATENCY(WL_A)) dut_a (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .read_data(read_data),
    .read_valid(read_valid), .write_done(write_done), .prot_err(prot_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2), .WRITE_LATENCY(3)) dut_b (
    .clk(clk), .reset(b_reset), .req_read(b_req_read), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .stall(b_stall), .read_data(b_read_data),
    .read_valid(b_read_valid), .write_done(b_write_done), .prot_err(b_prot_err)
  );

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  exp_t        cmp_e;
  logic [31:0] model_mem [256];
  logic [31:0] last_rd = '0;
  int          rv_cnt = 0;
  int          wd_cnt = 0;
  int          pe_cnt = 0;

  // Per-cycle comparison of instance A against the model timeline.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      tests++;
      if (stall !== cmp_e.stall || read_valid !== cmp_e.rv || write_done !== cmp_e.wd ||
          prot_err !== cmp_e.pe || read_data !== cmp_e.rd) begin
        fails++;
        $display("FAIL cycle t=%0t: got stall=%b rv=%b rd=%h wd=%b pe=%b, want stall=%b rv=%b rd=%h wd=%b pe=%b",
                 $time, stall, read_valid, read_data, write_done, prot_err,
                 cmp_e.stall, cmp_e.rv, cmp_e.rd, cmp_e.wd, cmp_e.pe);
      end
      if (read_valid === 1'b1) begin
        last_rd = read_data;
        rv_cnt++;
      end
      if (write_done === 1'b1) wd_cnt++;
      if (prot_err === 1'b1) pe_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Queue this cycle's expectation, then move to just after the next edge.
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = '{stall: 1'b0, rv: 1'b0, wd: 1'b0, pe: 1'b0, rd: 32'd0};
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < n; i++) step(e);
  endtask

  // One request on instance A: stall for the latency (misaligned counts as
  // 1), then a completion cycle. Inputs are scrambled while busy and held
  // through the completion cycle, neither of which may change the outcome.
  task automatic xact(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    bit          mis;
    int          lat;
    logic [7:0]  idx;
    mis = (addr[1:0] != 2'b00);
    lat = mis ? 1 : (wr ? WL_A : RL_A);
    idx = addr[9:2];
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    e = '{stall: 1'b1, rv: 1'b0, wd: 1'b0, pe: (mis || (rd && wr)), rd: 32'd0};
    step(e);
    e.pe = 1'b0;
    for (int c = 1; c < lat; c++) begin
      req_addr  = $urandom;
      req_wdata = $urandom;
      step(e);
    end
    req_addr  = addr;
    req_wdata = wd;
    e.stall = 1'b0;
    if (wr) begin
      e.wd = 1'b1;
      if (!mis) model_mem[idx] = wd;
    end else begin
      e.rv = 1'b1;
      e.rd = mis ? 32'd0 : model_mem[idx];
    end
    step(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    b_reset = 1'b1; b_req_read = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 32'(i * 7);
    end
    model_mem[3] = 32'd99;
    for (int i = 0; i < 256; i++) begin
      dut_a.u_array.memory[i] = model_mem[i];
    end
    dut_b.u_array.memory[4] = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    b_reset = 1'b0;

    // Reset state on both instances.
    idle(2);
    @(negedge clk);
    check("b_reset_stall", {31'd0, b_stall}, 32'd0);
    check("b_reset_rdata", b_read_data, 32'd0);
    @(posedge clk);
    #1;

    xact(1'b1, 1'b0, 32'd12, 32'd0);
    check("load12_data", last_rd, 32'd99);

    xact(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF);
    xact(1'b1, 1'b0, 32'd8, 32'd0);
    check("store_then_load8", last_rd, 32'hDEAD_BEEF);
    check("write_done_count", 32'(wd_cnt), 32'd1);
    idle(1);

    xact(1'b1, 1'b0, 32'd0, 32'd0);
    check("b2b_load0", last_rd, 32'd0);
    xact(1'b1, 1'b0, 32'd4, 32'd0);
    check("b2b_load4", last_rd, 32'd7);
    check("read_valid_count", 32'(rv_cnt), 32'd4);
    idle(1);

    xact(1'b1, 1'b0, 32'h402, 32'd0);
    check("misaligned_load_data", last_rd, 32'd0);
    check("prot_err_count1", 32'(pe_cnt), 32'd1);
    xact(1'b1, 1'b0, 32'h40C, 32'd0);
    check("wrap_load", last_rd, 32'd99);

    xact(1'b1, 1'b1, 32'd4, 32'd5);
    check("rw_prot_err", 32'(pe_cnt), 32'd2);
    xact(1'b1, 1'b0, 32'd4, 32'd0);
    check("rw_as_store", last_rd, 32'd5);

    xact(1'b0, 1'b1, 32'h9, 32'd123);
    xact(1'b1, 1'b0, 32'd8, 32'd0);
    check("misaligned_store_nowrite", last_rd, 32'hDEAD_BEEF);
    idle(2);

    // Instance B: reset while a 3-cycle store sits in BUSY_WR.
    b_req_write = 1'b1; b_req_addr = 32'd16; b_req_wdata = 32'h55;
    @(negedge clk);
    check("b_accept_stall", {31'd0, b_stall}, 32'd1);
    @(posedge clk);
    #1;
    b_reset = 1'b1;
    @(negedge clk);
    check("b_busy_stall", {31'd0, b_stall}, 32'd1);
    @(posedge clk);
    #1;
    b_reset = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    @(negedge clk);
    check("b_after_reset_stall", {31'd0, b_stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("b_no_write_done", {31'd0, b_write_done}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    b_req_read = 1'b1; b_req_addr = 32'd16;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("b_load_valid", {31'd0, b_read_valid}, 32'd1);
    check("b_store_dropped", b_read_data, 32'h1234_5678);
    @(posedge clk);
    #1;
    b_req_read = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
